// File: rtl/calc_axi_pkg.sv
// Shared definitions for the calculator AXI master: FSM states, register map,
// opcodes, AXI constants and job status codes.
package calc_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_RSP
  } state_t;

  // Register offsets inside the calculator slave, relative to BASE_ADDR.
  localparam logic [1:0] REG_OP1    = 2'd0;
  localparam logic [1:0] REG_OP2    = 2'd1;
  localparam logic [1:0] REG_OPCODE = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  // Opcodes understood by the calculator slave.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;
  localparam logic [1:0] OP_SHL = 2'd3;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SLVERR  = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_t;

endpackage

// File: rtl/calc_wait_timer.sv
// Wait-state watchdog for the AXI master.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_clear    - zero the count (asserted on every FSM state change)
//   i_enable   - count this cycle (FSM is waiting on a handshake)
//   o_expired  - high during the TIMEOUT-th consecutive waiting cycle
module calc_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // The count holds the number of waiting cycles already completed, so the
  // TIMEOUT-th waiting cycle is the one that sees TIMEOUT-1.
  assign o_expired = (r_count == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_axi_master.sv
// AXI master that runs one calculator job at a time: writes op1, op2 and
// opcode to the slave, reads back the result and returns it with a status.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cmd_*                          - job request (valid/ready) and operands
//   rsp_*                          - job result, status (00 ok/01 slverr/10 timeout)
//   aw*/w*/b*/ar*/r*               - single-beat AXI write and read channels
module calc_axi_master
  import calc_axi_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned          TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_op1,
  input  logic [DATA_WIDTH-1:0] cmd_op2,
  input  logic [DATA_WIDTH-1:0] cmd_opcode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [1:0]            rsp_err,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  input  logic [1:0]            rresp,
  output logic                  rready
);

  state_t                r_state, w_state_next;
  logic [1:0]            r_idx, w_idx_next;
  status_t               r_rsp_err, w_rsp_err_next;
  logic [DATA_WIDTH-1:0] r_rsp_result, w_rsp_result_next;
  logic [DATA_WIDTH-1:0] r_op1, r_op2, r_opcode;
  logic                  w_load;
  logic                  w_waiting;
  logic                  w_expired;

  assign w_waiting = r_state inside {S_AW, S_W, S_B, S_AR, S_R};

  calc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_state_next != r_state),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_rsp_err_next    = r_rsp_err;
    w_rsp_result_next = r_rsp_result;
    w_load            = 1'b0;
    unique case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_load            = 1'b1;
        w_idx_next        = 2'd0;
        w_rsp_err_next    = ST_OK;
        w_rsp_result_next = '0;
        w_state_next      = S_AW;
      end
      S_AW: if (awready) w_state_next = S_W;
      S_W:  if (wready)  w_state_next = S_B;
      S_B: if (bvalid) begin
        if (bresp != RESP_OKAY) begin
          // A failed write makes the remaining writes and the read pointless.
          w_rsp_err_next    = ST_SLVERR;
          w_rsp_result_next = '0;
          w_state_next      = S_RSP;
        end else if (r_idx == REG_OPCODE) begin
          w_state_next = S_AR;
        end else begin
          w_idx_next   = r_idx + 2'd1;
          w_state_next = S_AW;
        end
      end
      S_AR: if (arready) w_state_next = S_R;
      S_R: if (rvalid) begin
        w_rsp_err_next    = (rresp != RESP_OKAY) ? ST_SLVERR : ST_OK;
        w_rsp_result_next = (rresp != RESP_OKAY) ? '0 : rdata;
        w_state_next      = S_RSP;
      end
      S_RSP: if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Handshakes above take priority; abort only a wait that went nowhere.
    if (w_waiting && w_expired && (w_state_next == r_state)) begin
      w_rsp_err_next    = ST_TIMEOUT;
      w_rsp_result_next = '0;
      w_state_next      = S_RSP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_rsp_err    <= ST_OK;
      r_rsp_result <= '0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_rsp_err    <= w_rsp_err_next;
      r_rsp_result <= w_rsp_result_next;
    end
  end

  // NOTE: operand latches have no reset; they are only driven onto wdata in
  // the W state, which is reachable only after a job has loaded them.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_op1    <= cmd_op1;
      r_op2    <= cmd_op2;
      r_opcode <= cmd_opcode;
    end
  end

  // Addresses and data are gated by state so they read zero outside their
  // own phase, including straight after reset.
  always_comb begin
    wdata = '0;
    if (r_state == S_W) begin
      unique case (r_idx)
        REG_OP1: wdata = r_op1;
        REG_OP2: wdata = r_op2;
        default: wdata = r_opcode;
      endcase
    end
  end

  assign awaddr  = (r_state == S_AW) ? BASE_ADDR + ADDR_WIDTH'(r_idx) : '0;
  assign araddr  = (r_state == S_AR) ? BASE_ADDR + ADDR_WIDTH'(REG_RESULT) : '0;
  assign awvalid = (r_state == S_AW);
  assign wvalid  = (r_state == S_W);
  assign wlast   = (r_state == S_W);
  assign bready  = (r_state == S_B);
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);
  assign awlen   = 4'd0;
  assign awsize  = 3'd0;
  assign awburst = BURST_INCR;

  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign rsp_valid  = (r_state == S_RSP);
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_calc_axi_master.sv
// Self-checking bench for calc_axi_master with a behavioural calculator slave.
module tb_calc_axi_master;
  import calc_axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam logic [AW-1:0] BASE = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_op1, cmd_op2, cmd_opcode;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [1:0]    rsp_err;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [3:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;

  calc_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rresp(rresp), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model knobs and logs ----------------
  int            aw_delay = 0, w_delay = 0, err_wr = -1;
  bit            ar_stuck = 1'b0;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [AW-1:0] ar_addr;
  int            ar_count, b_count, viol, ar_run, last_ar_run;
  logic [DW-1:0] regs[4];

  function automatic logic [DW-1:0] calc(input logic [DW-1:0] a, b, input logic [1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      default: return a << b;
    endcase
  endfunction

  task automatic clear_logs();
    aw_log.delete();
    w_log.delete();
    ar_count = 0; b_count = 0; viol = 0; ar_run = 0; last_ar_run = 0;
    ar_addr = '1;
    for (int i = 0; i < 4; i++) regs[i] = '0;
  endtask

  // Slave acts 1 time unit after each falling edge, so both DUT outputs and
  // bench-driven inputs are settled when it looks at them.
  initial begin : slave
    int aw_cnt, w_cnt;
    bit p_rst, p_awpend, p_wpend;
    logic [AW-1:0] p_awaddr;
    logic [DW-1:0] p_wdata;
    aw_cnt = 0; w_cnt = 0; p_rst = 1'b1; p_awpend = 1'b0; p_wpend = 1'b0;
    p_awaddr = '0; p_wdata = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    clear_logs();
    forever begin
      @(negedge clk);
      #1;
      if (awlen !== 4'd0 || awsize !== 3'd0 || awburst !== 2'b01) viol++;
      if (wvalid && !wlast) viol++;
      if (awvalid && wvalid) viol++;
      if (!rst && !p_rst) begin
        if (p_awpend && (!awvalid || awaddr !== p_awaddr)) viol++;
        if (p_wpend && (!wvalid || wdata !== p_wdata)) viol++;
      end
      // AW channel
      if (awvalid && aw_cnt >= aw_delay) begin
        awready = 1'b1; aw_cnt = 0; aw_log.push_back(awaddr);
      end else begin
        awready = 1'b0; aw_cnt = awvalid ? aw_cnt + 1 : 0;
      end
      // W channel, never ahead of AW
      if (wvalid && w_cnt >= w_delay) begin
        wready = 1'b1; w_cnt = 0;
        if (aw_log.size() > w_log.size()) regs[aw_log[w_log.size()][1:0]] = wdata;
        else viol++;
        w_log.push_back(wdata);
      end else begin
        wready = 1'b0; w_cnt = wvalid ? w_cnt + 1 : 0;
      end
      // B channel: zero-wait response
      bvalid = bready;
      bresp  = (bready && b_count == err_wr) ? 2'b01 : 2'b00;
      if (bready) b_count++;
      // AR channel
      arready = arvalid && !ar_stuck;
      if (arready) begin ar_count++; ar_addr = araddr; end
      if (arvalid) ar_run++;
      else if (ar_run != 0) begin last_ar_run = ar_run; ar_run = 0; end
      // R channel
      rvalid = rready;
      rresp  = 2'b00;
      rdata  = calc(regs[REG_OP1], regs[REG_OP2], regs[REG_OPCODE][1:0]);
      p_rst    = rst;
      p_awpend = awvalid && !awready && !rst;
      p_wpend  = wvalid && !wready && !rst;
      p_awaddr = awaddr;
      p_wdata  = wdata;
    end
  end

  // One complete job from request to consumed response.
  task automatic run_job(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op, input logic [DW-1:0] exp_res,
                         input logic [1:0] exp_err, input int exp_nw, input int exp_rd,
                         input int exp_lat, input int hold);
    int t, lat, unstable;
    logic [DW-1:0] ops[3];
    logic [DW-1:0] r0;
    logic [1:0] e0;
    ops[0] = a; ops[1] = b; ops[2] = {6'd0, op};
    @(negedge clk);
    clear_logs();
    cmd_valid = 1'b1; cmd_op1 = a; cmd_op2 = b; cmd_opcode = {6'd0, op};
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check({name, " cmd_ready"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 500) begin @(negedge clk); lat++; end
    check({name, " rsp_valid"}, rsp_valid, 1'b1);
    if (exp_lat > 0) check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, rsp_result, exp_res);
    check({name, " err"}, rsp_err, exp_err);
    check({name, " cmd_ready low in RSP"}, cmd_ready, 1'b0);
    r0 = rsp_result; e0 = rsp_err; unstable = 0;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== r0 || rsp_err !== e0) unstable++;
    end
    check({name, " rsp stable"}, unstable, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, " rsp_valid drop"}, rsp_valid, 1'b0);
    check({name, " back to idle"}, cmd_ready, 1'b1);
    check({name, " aw count"}, aw_log.size(), exp_nw);
    check({name, " w count"}, w_log.size(), exp_nw);
    for (int k = 0; k < exp_nw && k < aw_log.size() && k < w_log.size(); k++) begin
      check($sformatf("%s awaddr[%0d]", name, k), aw_log[k], BASE + k);
      check($sformatf("%s wdata[%0d]", name, k), w_log[k], ops[k]);
    end
    check({name, " ar count"}, ar_count, exp_rd);
    if (exp_rd > 0) check({name, " araddr"}, ar_addr, BASE + 3);
    check({name, " protocol"}, viol, 0);
  endtask

  typedef struct {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [1:0]    opc;
    logic [DW-1:0] res;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vecs[0] = '{op1: 8'd5,   op2: 8'd3,   opc: OP_ADD, res: 8'd8};
    vecs[1] = '{op1: 8'd10,  op2: 8'd4,   opc: OP_SUB, res: 8'd6};
    vecs[2] = '{op1: 8'h0F,  op2: 8'd0,   opc: OP_NOT, res: 8'hF0};
    vecs[3] = '{op1: 8'd3,   op2: 8'd2,   opc: OP_SHL, res: 8'd12};
    vecs[4] = '{op1: 8'd200, op2: 8'd100, opc: OP_ADD, res: 8'd44};
    vecs[5] = '{op1: 8'd3,   op2: 8'd5,   opc: OP_SUB, res: 8'd254};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op1 = '0; cmd_op2 = '0; cmd_opcode = '0;
    repeat (3) @(negedge clk);
    check("reset valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
    check("reset cmd_ready", cmd_ready, 1'b0);
    check("reset rsp", {rsp_err, rsp_result}, 10'd0);
    check("reset addr", {awaddr, araddr}, 64'd0);
    rst = 1'b0;
    #1;
    check("idle cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), vecs[i].op1, vecs[i].op2, vecs[i].opc,
              vecs[i].res, ST_OK, 3, 1, 12, 0);

    // AW/W backpressure and a stalled response consumer.
    aw_delay = 3; w_delay = 3;
    run_job("backpressure", 8'd3, 8'd2, OP_SHL, 8'd12, ST_OK, 3, 1, -1, 5);
    aw_delay = 0; w_delay = 0;

    // Error response on the op2 write ends the job early.
    err_wr = 1;
    run_job("slverr", 8'd7, 8'd9, OP_ADD, 8'd0, ST_SLVERR, 2, 0, -1, 0);
    err_wr = -1;

    // AR never accepted: abort after TIMEOUT cycles, then a clean job.
    ar_stuck = 1'b1;
    run_job("timeout", 8'd1, 8'd2, OP_ADD, 8'd0, ST_TIMEOUT, 3, 0, -1, 0);
    check("timeout arvalid cycles", last_ar_run, 8);
    ar_stuck = 1'b0;
    run_job("after timeout", 8'd10, 8'd4, OP_SUB, 8'd6, ST_OK, 3, 1, 12, 0);

    // Reset pulsed during the second W beat.
    begin : reset_mid_op
      int t;
      w_delay = 3;
      @(negedge clk);
      clear_logs();
      cmd_valid = 1'b1; cmd_op1 = 8'h11; cmd_op2 = 8'h22; cmd_opcode = {6'd0, OP_ADD};
      @(negedge clk);
      cmd_valid = 1'b0;
      t = 0;
      while (!(wvalid && wdata == 8'h22) && t < 100) begin @(negedge clk); t++; end
      check("midop reached W2", wvalid, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("midop valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'd0);
      check("midop cmd_ready", cmd_ready, 1'b0);
      check("midop data", {awaddr, wdata, rsp_err}, 42'd0);
      rst = 1'b0;
      #1;
      check("midop idle", cmd_ready, 1'b1);
      w_delay = 0;
    end
    run_job("after reset", 8'h11, 8'h22, OP_ADD, 8'h33, ST_OK, 3, 1, 12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
